addsub_pipe: RTL
================

# addsub_pipe

Two-stage valid/ready pipeline wrapper around the vector lane's ADDSUB adder. Decodes the integer add/subtract opcodes (vadd, vsub, vrsub, vadc, vsbc and, optionally, unsigned saturating add/sub). Drives ADDSUB's operand, carry and mode inputs from a registered operand stage, and registers the result with carry/borrow and saturation flags for the lane writeback. Sits between the lane operand-select stage (upstream) and lane writeback (downstream). Throughput is one element per cycle.

## Interface
- DATA_WIDTH, 32, element width; matches the ADDSUB instance width.

- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- in_valid_i  in  1  operand beat valid
- in_ready_o  out  1  stage accepts a beat
- op_i  in  3  opcode: 000 ADD, 001 SUB, 010 RSUB, 011 ADC, 100 SBC, 101 SADDU, 110 SSUBU, 111 reserved
- vs2_i  in  DATA_WIDTH  vector source 2
- opnd_i  in  DATA_WIDTH  second operand, already muxed from vs1, scalar or immediate
- cin_i  in  1  v0 mask bit; used as carry-in (ADC) or borrow-in (SBC)
- out_valid_o  out  1  result valid
- out_ready_i  in  1  writeback accepts result
- res_o  out  DATA_WIDTH  result
- co_o  out  1  carry-out (add ops) or borrow-out (sub ops)
- sat_o  out  1  this result saturated
- sat_sticky_o  out  1  accumulated vxsat
- sat_clr_i  in  1  clear sat_sticky_o
- as_a_o, as_b_o  out  DATA_WIDTH  to ADDSUB a_i, b_i
- as_ci_o  out  1  to ADDSUB ci_i
- as_add_sub_o  out  1  to ADDSUB add_sub_i; 0 = add, 1 = subtract
- as_sum_i  in  DATA_WIDTH  from ADDSUB sum_o
- as_co_i  in  1  from ADDSUB co_o; in subtract mode it is borrow-out

## Operation
- S1 register: holds op, vs2, opnd, cin and s1_valid. It is loaded on in_valid_i & in_ready_o.
- ADDSUB drive: combinational from S1 only, never from the raw inputs.
  - ADD: a=vs2, b=opnd, ci=0, as=0
  - SUB: a=vs2, b=opnd, ci=0, as=1
  - RSUB: a=opnd, b=vs2, ci=0, as=1
  - ADC: a=vs2, b=opnd, ci=cin, as=0
  - SBC: a=vs2, b=opnd, ci=cin, as=1
  - SADDU: as ADD
  - SSUBU: as SUB
  - 111: decoded as ADD
- S2 register: captures res, co, sat and s2_valid from S1 when S1 advances.
- Advance rules:
  - s2_adv = ~s2_valid | out_ready_i
  - S1 moves to S2 when s1_valid & s2_adv; S2 is loaded and s2_valid is set.
  - If ~s1_valid & s2_adv, s2_valid clears.
- Ready: in_ready_o = rst_ni & (~s1_valid | s2_adv). This is a combinational path from out_ready_i; it is accepted by design.
- Saturation (ALU_SAT_EN only):
  - SADDU with co=1 → res = all ones, sat = 1.
  - SSUBU with borrow = 1 → res = 0, sat = 1.
  - All other ops have sat = 0. co_o always reports the raw ADDSUB flag.
- Sticky flag: sat_sticky_o sets on out_valid_o & out_ready_i & sat_o and holds until sat_clr_i. If both occur in the same cycle, set wins.
- Output stability: res_o, co_o and sat_o hold while out_valid_o & ~out_ready_i.

## Timing
- Latency: accept in cycle N → out_valid_o in cycle N+2, assuming no stall.
- Back-to-back: one beat per cycle with out_ready_i held high.
- Stall capacity: with out_ready_i low, at most 2 beats are held (S1 + S2). in_ready_o drops once both are full.
- Simultaneous events: with both stages full, asserting out_ready_i accepts a new input in the same cycle.
- Reset (rst_ni low at a clock edge): s1_valid, s2_valid, res_o, co_o, sat_o and sat_sticky_o go to 0. Registered operands go to 0. in_ready_o is 0 while rst_ni is low.
- Reset mid-operation: in-flight beats are dropped silently and nothing is emitted.
- Width rules: all arithmetic is DATA_WIDTH modulo 2^DATA_WIDTH. Overflow appears only via co_o.

## Configuration
- ALU_SAT_EN defined:
  - SADDU and SSUBU saturate as described.
  - sat_o and sat_sticky_o are live.
- ALU_SAT_EN undefined:
  - 101 decodes as ADD and 110 as SUB, with no clamping.
  - sat_o and sat_sticky_o are tied 0; sat_clr_i is ignored.

## Test plan
- ADD 0xFFFFFFFF + 0x00000001, out_ready_i=1 → two cycles later res=0x00000000, co=1, sat=0.
- RSUB vs2=5, opnd=3 → res=0xFFFFFFFE, co=1 (borrow). SBC vs2=10, opnd=3, cin=1 → res=6, co=0.
- Streaming and stall: stream 4 beats 1..4 as ADD with 0. Hold out_ready_i low from the 2nd output onward → in_ready_o=0 after two beats are buffered, res_o stays stable. Release out_ready_i → outputs 1..4 in order, no loss or duplication.
- Saturation (ALU_SAT_EN):
  - SADDU 0xFFFFFFF0 + 0x20 → res=0xFFFFFFFF, sat=1, sat_sticky_o=1 after the handshake.
  - SSUBU 3 − 7 → res=0, sat=1.
  - sat_clr_i → sat_sticky_o=0.
  - Without the macro, the same SADDU beat gives res=0x00000010, sat=0.
- Reset mid-operation: with both stages full, drive rst_ni low for one edge → out_valid_o=0, res_o=0, sat_sticky_o=0. After release, the first new beat appears 2 cycles after acceptance.

Source files
------------

// File: rtl/addsub_pipe.sv
// addsub_pipe: two-stage valid/ready wrapper around the lane ADDSUB adder.
// S1 registers the operand beat and drives ADDSUB combinationally. S2
// registers the result, the carry/borrow flag and the saturation flag for
// writeback.
// Optional feature macro: ALU_SAT_EN enables unsigned saturating add/sub
// (SADDU/SSUBU clamping, sat_o, sat_sticky_o). When it is undefined,
// SADDU decodes as ADD, SSUBU decodes as SUB, and the saturation outputs are tied 0.
module addsub_pipe #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] vs2_i,
    input  logic [DATA_WIDTH-1:0] opnd_i,
    input  logic                  cin_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] res_o,
    output logic                  co_o,
    output logic                  sat_o,
    output logic                  sat_sticky_o,
    input  logic                  sat_clr_i,
    output logic [DATA_WIDTH-1:0] as_a_o,
    output logic [DATA_WIDTH-1:0] as_b_o,
    output logic                  as_ci_o,
    output logic                  as_add_sub_o,
    input  logic [DATA_WIDTH-1:0] as_sum_i,
    input  logic                  as_co_i
);

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_SUB   = 3'b001,
        OP_RSUB  = 3'b010,
        OP_ADC   = 3'b011,
        OP_SBC   = 3'b100,
        OP_SADDU = 3'b101,
        OP_SSUBU = 3'b110,
        OP_RSVD  = 3'b111
    } op_e;

    // Stage 1 (operand) state
    logic                  s1_valid_q, s1_valid_d;
    op_e                   s1_op_q,    s1_op_d;
    logic [DATA_WIDTH-1:0] s1_vs2_q,   s1_vs2_d;
    logic [DATA_WIDTH-1:0] s1_opnd_q,  s1_opnd_d;
    logic                  s1_cin_q,   s1_cin_d;

    // Stage 2 (result) state
    logic                  s2_valid_q, s2_valid_d;
    logic [DATA_WIDTH-1:0] res_q,      res_d;
    logic                  co_q,       co_d;

    logic s2_adv;
    logic accept;

    assign s2_adv     = ~s2_valid_q | out_ready_i;
    assign in_ready_o = rst_ni & (~s1_valid_q | s2_adv);
    assign accept     = in_valid_i & in_ready_o;

    // S1 next state: load on handshake, otherwise empty once the beat moves to S2
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_vs2_d   = s1_vs2_q;
        s1_opnd_d  = s1_opnd_q;
        s1_cin_d   = s1_cin_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = op_e'(op_i);
            s1_vs2_d   = vs2_i;
            s1_opnd_d  = opnd_i;
            s1_cin_d   = cin_i;
        end else if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
    end

    // S1 registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_vs2_q   <= '0;
            s1_opnd_q  <= '0;
            s1_cin_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_vs2_q   <= s1_vs2_d;
            s1_opnd_q  <= s1_opnd_d;
            s1_cin_q   <= s1_cin_d;
        end
    end

    // ADDSUB operand/mode decode from registered S1 only
    always_comb begin
        as_a_o       = s1_vs2_q;
        as_b_o       = s1_opnd_q;
        as_ci_o      = 1'b0;
        as_add_sub_o = 1'b0;
        case (s1_op_q)
            OP_SUB: begin
                as_add_sub_o = 1'b1;
            end
            OP_RSUB: begin
                as_a_o       = s1_opnd_q;
                as_b_o       = s1_vs2_q;
                as_add_sub_o = 1'b1;
            end
            OP_ADC: begin
                as_ci_o = s1_cin_q;
            end
            OP_SBC: begin
                as_ci_o      = s1_cin_q;
                as_add_sub_o = 1'b1;
            end
            OP_SSUBU: begin
                as_add_sub_o = 1'b1;
            end
            default: begin
                // ADD, SADDU and the reserved code all add
            end
        endcase
    end

`ifdef ALU_SAT_EN
    logic sat_q, sat_d;
    logic sticky_q, sticky_d;

    // S2 next state with unsigned saturation clamp on SADDU/SSUBU
    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        co_d       = co_q;
        sat_d      = sat_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = as_sum_i;
                co_d  = as_co_i;
                sat_d = 1'b0;
                if (s1_op_q == OP_SADDU && as_co_i) begin
                    res_d = '1;
                    sat_d = 1'b1;
                end else if (s1_op_q == OP_SSUBU && as_co_i) begin
                    res_d = '0;
                    sat_d = 1'b1;
                end
            end
        end
    end

    // Sticky vxsat: a saturating handshake in the same cycle as a clear keeps it set
    always_comb begin
        sticky_d = sticky_q;
        if (sat_clr_i) begin
            sticky_d = 1'b0;
        end
        if (s2_valid_q && out_ready_i && sat_q) begin
            sticky_d = 1'b1;
        end
    end

    // Saturation state registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sat_q    <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            sat_q    <= sat_d;
            sticky_q <= sticky_d;
        end
    end

    assign sat_o        = sat_q;
    assign sat_sticky_o = sticky_q;
`else
    logic unused_sat_clr;

    // S2 next state: raw ADDSUB result and flag
    always_comb begin
        s2_valid_d = s2_valid_q;
        res_d      = res_q;
        co_d       = co_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                res_d = as_sum_i;
                co_d  = as_co_i;
            end
        end
    end

    assign unused_sat_clr = sat_clr_i;
    assign sat_o          = 1'b0;
    assign sat_sticky_o   = 1'b0;
`endif

    // S2 registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s2_valid_q <= 1'b0;
            res_q      <= '0;
            co_q       <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            res_q      <= res_d;
            co_q       <= co_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign res_o       = res_q;
    assign co_o        = co_q;

endmodule
